// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I-subset datapath.
// Sequences fetch/decode/execute/memory/writeback, counts retirements, traps illegal encodings.

module multicycle_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic [3:0]       ALU_control,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_sel,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             instr_retired,
   output logic             illegal,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [3:0]       state
);

   localparam int unsigned ST_W = 4;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_LSW = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_RS1   = 2'd1;
   localparam logic [1:0] SRCA_OLDPC = 2'd2;
   localparam logic [1:0] SRCB_RS2   = 2'd0;
   localparam logic [1:0] SRCB_FOUR  = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] WB_ALU     = 2'd0;
   localparam logic [1:0] WB_MDR     = 2'd1;
   localparam logic [1:0] WB_PC      = 2'd2;

   typedef enum logic [ST_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_ALU_WB   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_MEM_WB   = 4'd7,
      S_MEM_WR   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_illegal;

   logic             w_r_legal;
   logic             w_i_legal;
   logic             w_lsw_legal;
   logic [3:0]       w_alu_ctl;
   logic [1:0]       w_src_a;
   logic [1:0]       w_src_b;
   logic             w_iord;
   logic             w_mem_read;
   logic             w_mem_write;
   logic             w_ir_write;
   logic             w_pc_write;
   logic             w_pc_sel;
   logic             w_reg_write;
   logic [1:0]       w_wb_sel;
   logic             w_retire;

   // ALU operation from funct3; sub only selected for R-type with funct7_5 set
   function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic sub_en);
      logic [3:0] op;
      op = ALU_ADD;
      case (f3)
         F3_ADD:  op = sub_en ? ALU_SUB : ALU_ADD;
         F3_AND:  op = ALU_AND;
         F3_OR:   op = ALU_OR;
         F3_SLT:  op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   assign w_i_legal   = (funct3 == F3_ADD) || (funct3 == F3_AND) ||
                        (funct3 == F3_OR)  || (funct3 == F3_SLT);
   assign w_r_legal   = (funct3 == F3_ADD) ||
                        (!funct7_5 && ((funct3 == F3_AND) || (funct3 == F3_OR) ||
                                       (funct3 == F3_SLT)));
   assign w_lsw_legal = (funct3 == F3_LSW);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and control decode
   always_comb begin
      w_next_state = r_state;
      w_alu_ctl    = ALU_ADD;
      w_src_a      = SRCA_PC;
      w_src_b      = SRCB_RS2;
      w_iord       = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_sel     = 1'b0;
      w_reg_write  = 1'b0;
      w_wb_sel     = WB_ALU;
      w_retire     = 1'b0;

      case (r_state)
         S_FETCH: begin
            w_iord     = 1'b0;
            w_mem_read = 1'b1;
            w_src_a    = SRCA_PC;
            w_src_b    = SRCB_FOUR;
            if (mem_ready) begin
               w_ir_write   = 1'b1;
               w_pc_write   = 1'b1;
               w_pc_sel     = 1'b0;
               w_next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            w_src_a = SRCA_OLDPC;
            w_src_b = SRCB_IMM;
            case (opcode)
               OP_R:      w_next_state = w_r_legal   ? S_EXEC_R   : S_ILLEGAL;
               OP_I:      w_next_state = w_i_legal   ? S_EXEC_I   : S_ILLEGAL;
               OP_LOAD,
               OP_STORE:  w_next_state = w_lsw_legal ? S_MEM_ADDR : S_ILLEGAL;
               OP_BRANCH: w_next_state = (funct3 == F3_BEQ) ? S_BRANCH : S_ILLEGAL;
               OP_JAL:    w_next_state = S_JAL;
               default:   w_next_state = S_ILLEGAL;
            endcase
         end
         S_EXEC_R: begin
            w_src_a      = SRCA_RS1;
            w_src_b      = SRCB_RS2;
            w_alu_ctl    = f_alu_op(funct3, funct7_5);
            w_next_state = S_ALU_WB;
         end
         S_EXEC_I: begin
            w_src_a      = SRCA_RS1;
            w_src_b      = SRCB_IMM;
            w_alu_ctl    = f_alu_op(funct3, 1'b0);
            w_next_state = S_ALU_WB;
         end
         S_ALU_WB: begin
            w_reg_write  = 1'b1;
            w_wb_sel     = WB_ALU;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
         end
         S_MEM_ADDR: begin
            w_src_a      = SRCA_RS1;
            w_src_b      = SRCB_IMM;
            w_next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            w_iord     = 1'b1;
            w_mem_read = 1'b1;
            if (mem_ready) begin
               w_next_state = S_MEM_WB;
            end
         end
         S_MEM_WB: begin
            w_reg_write  = 1'b1;
            w_wb_sel     = WB_MDR;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
         end
         S_MEM_WR: begin
            w_iord      = 1'b1;
            w_mem_write = 1'b1;
            if (mem_ready) begin
               w_retire     = 1'b1;
               w_next_state = S_FETCH;
            end
         end
         S_BRANCH: begin
            w_src_a      = SRCA_RS1;
            w_src_b      = SRCB_RS2;
            w_alu_ctl    = ALU_SUB;
            w_pc_sel     = 1'b1;
            w_pc_write   = Zero;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
         end
         S_JAL: begin
            // PC already holds old PC + 4, so it is the link value
            w_pc_write   = 1'b1;
            w_pc_sel     = 1'b1;
            w_reg_write  = 1'b1;
            w_wb_sel     = WB_PC;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
         end
         S_ILLEGAL: begin
            w_next_state = S_ILLEGAL;
         end
         default: begin
            w_next_state = S_ILLEGAL;
         end
      endcase
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_retire) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Sticky trap flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_illegal <= 1'b0;
      end else if (w_next_state == S_ILLEGAL) begin
         r_illegal <= 1'b1;
      end
   end

   // Enables are suppressed during reset so an in-flight access never commits
   assign mem_read      = w_mem_read  & rst_n;
   assign mem_write     = w_mem_write & rst_n;
   assign ir_write      = w_ir_write  & rst_n;
   assign pc_write      = w_pc_write  & rst_n;
   assign reg_write     = w_reg_write & rst_n;
   assign instr_retired = w_retire    & rst_n;

   assign ALU_control = w_alu_ctl;
   assign alu_src_a   = w_src_a;
   assign alu_src_b   = w_src_b;
   assign iord        = w_iord;
   assign pc_sel      = w_pc_sel;
   assign wb_sel      = w_wb_sel;
   assign illegal     = r_illegal;
   assign retired_cnt = r_cnt;
   assign state       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: expected per-cycle control words
// are queued by the stimulus process and checked by an independent monitor.

module tb_multicycle_ctrl;

   localparam int unsigned CW = 4;

   localparam int CL_R   = 0;
   localparam int CL_I   = 1;
   localparam int CL_LW  = 2;
   localparam int CL_SW  = 3;
   localparam int CL_BEQ = 4;
   localparam int CL_JAL = 5;
   localparam int CL_ILL = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          funct7_5;
   logic          Zero;
   logic          mem_ready;
   logic [3:0]    ALU_control;
   logic [1:0]    alu_src_a;
   logic [1:0]    alu_src_b;
   logic          iord;
   logic          mem_read;
   logic          mem_write;
   logic          ir_write;
   logic          pc_write;
   logic          pc_sel;
   logic          reg_write;
   logic [1:0]    wb_sel;
   logic          instr_retired;
   logic          illegal;
   logic [CW-1:0] retired_cnt;
   logic [3:0]    state;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .Zero(Zero), .mem_ready(mem_ready), .ALU_control(ALU_control),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
      .reg_write(reg_write), .wb_sel(wb_sel), .instr_retired(instr_retired),
      .illegal(illegal), .retired_cnt(retired_cnt), .state(state)
   );

   typedef struct packed {
      logic [3:0]    st;
      logic [3:0]    alu;
      logic [1:0]    a;
      logic [1:0]    b;
      logic          iord;
      logic          mrd;
      logic          mwr;
      logic          irw;
      logic          pcw;
      logic          pcs;
      logic          rgw;
      logic [1:0]    wb;
      logic          ret;
      logic          ill;
      logic [CW-1:0] cnt;
   } rec_t;

   rec_t        exp_q[$];
   string       tag_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned m_cnt   = 0;
   logic        m_ill   = 1'b0;
   int          cyc_in_instr;

   // Monitor: compare the DUT's control word each cycle against the queued expectation
   always @(negedge clk) begin
      rec_t  e;
      rec_t  act;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         act.st   = state;        act.alu = ALU_control; act.a   = alu_src_a;
         act.b    = alu_src_b;    act.iord = iord;       act.mrd = mem_read;
         act.mwr  = mem_write;    act.irw = ir_write;    act.pcw = pc_write;
         act.pcs  = pc_sel;       act.rgw = reg_write;   act.wb  = wb_sel;
         act.ret  = instr_retired; act.ill = illegal;    act.cnt = retired_cnt;
         n_tests++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got st=%0d alu=%b a=%0d b=%0d iord=%b rd=%b wr=%b irw=%b pcw=%b pcs=%b rgw=%b wb=%0d ret=%b ill=%b cnt=%0d | want st=%0d alu=%b a=%0d b=%0d iord=%b rd=%b wr=%b irw=%b pcw=%b pcs=%b rgw=%b wb=%0d ret=%b ill=%b cnt=%0d",
                     t, act.st, act.alu, act.a, act.b, act.iord, act.mrd, act.mwr, act.irw,
                     act.pcw, act.pcs, act.rgw, act.wb, act.ret, act.ill, act.cnt,
                     e.st, e.alu, e.a, e.b, e.iord, e.mrd, e.mwr, e.irw,
                     e.pcw, e.pcs, e.rgw, e.wb, e.ret, e.ill, e.cnt);
         end
      end
   end

   function automatic rec_t base(input int st);
      rec_t r;
      r     = '0;
      r.st  = 4'(st);
      r.alu = 4'b0010;
      r.ill = m_ill;
      r.cnt = CW'(m_cnt);
      return r;
   endfunction

   // Instruction class from the encoding rules of the subset
   function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      bit alu_f3;
      alu_f3 = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
      if (op == 7'b0110011) return (alu_f3 && (f3 == 3'b000 || !f7)) ? CL_R : CL_ILL;
      if (op == 7'b0010011) return alu_f3 ? CL_I : CL_ILL;
      if (op == 7'b0000011) return (f3 == 3'b010) ? CL_LW : CL_ILL;
      if (op == 7'b0100011) return (f3 == 3'b010) ? CL_SW : CL_ILL;
      if (op == 7'b1100011) return (f3 == 3'b000) ? CL_BEQ : CL_ILL;
      if (op == 7'b1101111) return CL_JAL;
      return CL_ILL;
   endfunction

   function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic f7, input bit is_r);
      case (f3)
         3'b111:  return 4'b0000;
         3'b110:  return 4'b0001;
         3'b010:  return 4'b0111;
         default: return (is_r && f7) ? 4'b0110 : 4'b0010;
      endcase
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(1));
   endfunction

   // Drive one cycle's inputs and queue that cycle's expected control word
   task automatic step(input rec_t e, input string t, input logic mr, input logic z,
                       input logic rn);
      mem_ready = mr;
      Zero      = z;
      rst_n     = rn;
      exp_q.push_back(e);
      tag_q.push_back(t);
      cyc_in_instr++;
      @(posedge clk);
      #1;
   endtask

   task automatic retire();
      m_cnt = (m_cnt + 1) % (1 << CW);
   endtask

   task automatic fetch_decode(input int fstall, input string t);
      rec_t r;
      for (int i = 0; i < fstall; i++) begin
         r = base(0); r.mrd = 1'b1; r.b = 2'd1;
         step(r, t, 1'b0, rbit(), 1'b1);
      end
      r = base(0); r.mrd = 1'b1; r.b = 2'd1; r.irw = 1'b1; r.pcw = 1'b1;
      step(r, t, 1'b1, rbit(), 1'b1);
      r = base(1); r.a = 2'd2; r.b = 2'd2;
      step(r, t, rbit(), rbit(), 1'b1);
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input int fstall, input int mstall, input logic z,
                            input string t);
      rec_t r;
      int   cl;
      opcode       = op;
      funct3       = f3;
      funct7_5     = f7;
      cyc_in_instr = 0;
      fetch_decode(fstall, t);
      cl = classify(op, f3, f7);
      case (cl)
         CL_R, CL_I: begin
            r = base(cl == CL_R ? 2 : 3); r.a = 2'd1; r.b = (cl == CL_R) ? 2'd0 : 2'd2;
            r.alu = exp_alu(f3, f7, cl == CL_R);
            step(r, t, rbit(), rbit(), 1'b1);
            r = base(4); r.rgw = 1'b1; r.ret = 1'b1;
            step(r, t, rbit(), rbit(), 1'b1);
            retire();
         end
         CL_LW, CL_SW: begin
            r = base(5); r.a = 2'd1; r.b = 2'd2;
            step(r, t, rbit(), rbit(), 1'b1);
            for (int i = 0; i <= mstall; i++) begin
               r = base(cl == CL_LW ? 6 : 8); r.iord = 1'b1;
               if (cl == CL_LW) r.mrd = 1'b1; else r.mwr = 1'b1;
               if (cl == CL_SW && i == mstall) r.ret = 1'b1;
               step(r, t, 1'(i == mstall), rbit(), 1'b1);
            end
            if (cl == CL_LW) begin
               r = base(7); r.rgw = 1'b1; r.wb = 2'd1; r.ret = 1'b1;
               step(r, t, rbit(), rbit(), 1'b1);
            end
            retire();
         end
         CL_BEQ: begin
            r = base(9); r.a = 2'd1; r.alu = 4'b0110; r.pcs = 1'b1; r.pcw = z; r.ret = 1'b1;
            step(r, t, rbit(), z, 1'b1);
            retire();
         end
         CL_JAL: begin
            r = base(10); r.pcw = 1'b1; r.pcs = 1'b1; r.rgw = 1'b1; r.wb = 2'd2; r.ret = 1'b1;
            step(r, t, rbit(), rbit(), 1'b1);
            retire();
         end
         default: begin
            m_ill = 1'b1;
            for (int i = 0; i < 3; i++) begin
               r = base(11);
               step(r, t, rbit(), rbit(), 1'b1);
            end
            // One reset edge leaves the trap; flag is still visible during that cycle
            r = base(11);
            step(r, t, rbit(), rbit(), 1'b0);
            m_ill = 1'b0;
            m_cnt = 0;
         end
      endcase
   endtask

   // Store aborted by reset while waiting on memory
   task automatic sw_reset(input string t);
      rec_t r;
      opcode   = 7'b0100011;
      funct3   = 3'b010;
      funct7_5 = 1'b0;
      fetch_decode(0, t);
      r = base(5); r.a = 2'd1; r.b = 2'd2;
      step(r, t, rbit(), rbit(), 1'b1);
      r = base(8); r.iord = 1'b1;
      step(r, t, 1'b0, rbit(), 1'b0);
      m_cnt = 0;
   endtask

   initial begin
      logic [6:0] ops [6];
      logic [2:0] f3s [4];
      logic [6:0] op;
      logic [2:0] f3;
      ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
      ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
      f3s[0] = 3'b000; f3s[1] = 3'b111; f3s[2] = 3'b110; f3s[3] = 3'b010;

      rst_n = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; Zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0, "add");
      run_instr(7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0, "sub");
      run_instr(7'b0110011, 3'b010, 1'b0, 0, 0, 1'b0, "slt");
      run_instr(7'b0110011, 3'b111, 1'b0, 0, 0, 1'b0, "and");
      run_instr(7'b0110011, 3'b110, 1'b0, 0, 0, 1'b0, "or");
      run_instr(7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0, "addi_f7");
      run_instr(7'b0000011, 3'b010, 1'b0, 3, 3, 1'b0, "lw_stall");
      n_tests++;
      if (cyc_in_instr != 11) begin
         n_fail++;
         $display("FAIL lw_latency: got %0d cycles, want 11", cyc_in_instr);
      end
      run_instr(7'b0100011, 3'b010, 1'b0, 0, 0, 1'b0, "sw");
      run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1, "beq_taken");
      run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0, "beq_not");
      run_instr(7'b1101111, 3'b101, 1'b1, 0, 0, 1'b0, "jal");
      run_instr(7'b0110011, 3'b111, 1'b1, 0, 0, 1'b0, "and_f7_illegal");
      run_instr(7'b0000000, 3'b000, 1'b0, 0, 0, 1'b0, "op0_illegal");
      run_instr(7'b0010011, 3'b000, 1'b0, 0, 0, 1'b0, "after_reset");
      sw_reset("sw_reset");
      run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0, "after_sw_reset");

      for (int n = 0; n < 250; n++) begin
         op = ($urandom_range(99) < 12) ? 7'($urandom) : ops[$urandom_range(5)];
         f3 = ($urandom_range(99) < 75) ? f3s[$urandom_range(3)] : 3'($urandom);
         run_instr(op, f3, rbit(), $urandom_range(2), $urandom_range(2), rbit(), "random");
      end

      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
